gesummv_y_checker: RTL and testbench



---
 rtl/gesummv_y_checker.sv | 132 +++++++++++++
 tb/tb_gesummv_y_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gesummv_y_checker.sv
// Snoops the HIR and HLS Y write ports into shadow arrays, then compares them
// element by element and reports pass/fail, mismatch count and first bad index.
module gesummv_y_checker #(
   parameter int WIDTH   = 32,
   parameter int SIZE    = 8,
   parameter int ADDR_W  = 3,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              a_wr_en,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [WIDTH-1:0]  a_wr_data,
   input  logic              b_wr_en,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [WIDTH-1:0]  b_wr_data,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [ADDR_W:0]   mismatch_count,
   output logic [ADDR_W-1:0] first_mismatch_addr
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SIZE - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   MC_ONE   = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0]  r_mem_a [SIZE];
   logic [WIDTH-1:0]  r_mem_b [SIZE];
   logic [SIZE-1:0]   r_bit_a;
   logic [SIZE-1:0]   r_bit_b;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W:0]   r_mcnt;
   logic [ADDR_W-1:0] r_first;
   logic              r_timeout;
   logic              r_pass;

   logic              w_all_written;
   logic              w_cnt_end;
   logic              w_diff;
   logic [ADDR_W:0]   w_mcnt_next;
   logic              w_capture;

   assign w_all_written = (&r_bit_a) && (&r_bit_b);
   assign w_cnt_end     = (r_cnt == CNT_END);
   assign w_diff        = (r_mem_a[r_idx] != r_mem_b[r_idx]);
   assign w_mcnt_next   = w_diff ? (r_mcnt + MC_ONE) : r_mcnt;
   assign w_capture     = !rst && !start && (r_state == S_CAPTURE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // start from any state restarts the run
   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = S_CAPTURE;
      end else begin
         case (r_state)
            S_CAPTURE: begin
               if (w_all_written)  w_next = S_COMPARE;
               else if (w_cnt_end) w_next = S_DONE;
            end
            S_COMPARE: if (r_idx == IDX_LAST) w_next = S_DONE;
            default: ;
         endcase
      end
   end

   // shadow arrays carry no reset; only bitmaps say what is valid
   always_ff @(posedge clk) begin
      if (w_capture && a_wr_en) r_mem_a[a_addr] <= a_wr_data;
      if (w_capture && b_wr_en) r_mem_b[b_addr] <= b_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || start) begin
         r_bit_a   <= '0;
         r_bit_b   <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_mcnt    <= '0;
         r_first   <= '0;
         r_timeout <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         case (r_state)
            S_CAPTURE: begin
               r_cnt <= r_cnt + CNT_ONE;
               r_idx <= '0;
               if (a_wr_en) r_bit_a[a_addr] <= 1'b1;
               if (b_wr_en) r_bit_b[b_addr] <= 1'b1;
               if (!w_all_written && w_cnt_end) begin
                  r_timeout <= 1'b1;
                  r_pass    <= 1'b0;
               end
            end
            S_COMPARE: begin
               r_idx  <= r_idx + IDX_ONE;
               r_mcnt <= w_mcnt_next;
               if (w_diff && (r_mcnt == '0)) r_first <= r_idx;
               if (r_idx == IDX_LAST) r_pass <= (w_mcnt_next == '0);
            end
            default: ;
         endcase
      end
   end

   assign done                = (r_state == S_DONE);
   assign pass                = r_pass;
   assign timeout             = r_timeout;
   assign mismatch_count      = r_mcnt;
   assign first_mismatch_addr = r_first;

endmodule

// File: tb/tb_gesummv_y_checker.sv
// Directed bench for gesummv_y_checker: matching, mismatching, rewrite,
// timeout, reset-abort and restart runs with hand-computed results.
module tb_gesummv_y_checker;

   localparam int WIDTH  = 32;
   localparam int SIZE   = 8;
   localparam int ADDR_W = 3;
   localparam int TMO    = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              a_wr_en = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0;
   logic [WIDTH-1:0]  a_wr_data = '0;
   logic              b_wr_en = 1'b0;
   logic [ADDR_W-1:0] b_addr = '0;
   logic [WIDTH-1:0]  b_wr_data = '0;
   logic              done;
   logic              pass;
   logic              timeout;
   logic [ADDR_W:0]   mismatch_count;
   logic [ADDR_W-1:0] first_mismatch_addr;

   int n_err = 0;
   int n_chk = 0;
   int lat;

   logic [WIDTH-1:0] da [SIZE];
   logic [WIDTH-1:0] db [SIZE];

   gesummv_y_checker #(
      .WIDTH  (WIDTH),
      .SIZE   (SIZE),
      .ADDR_W (ADDR_W),
      .TIMEOUT(TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .a_wr_en            (a_wr_en),
      .a_addr             (a_addr),
      .a_wr_data          (a_wr_data),
      .b_wr_en            (b_wr_en),
      .b_addr             (b_addr),
      .b_wr_data          (b_wr_data),
      .done               (done),
      .pass               (pass),
      .timeout            (timeout),
      .mismatch_count     (mismatch_count),
      .first_mismatch_addr(first_mismatch_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // A writes addresses ascending, B descending; skip masks leave addresses unwritten
   task automatic do_writes(input logic [SIZE-1:0] skip_a, input logic [SIZE-1:0] skip_b);
      for (int i = 0; i < SIZE; i++) begin
         a_wr_en   = !skip_a[i];
         a_addr    = ADDR_W'(i);
         a_wr_data = da[i];
         b_wr_en   = !skip_b[SIZE-1-i];
         b_addr    = ADDR_W'(SIZE-1-i);
         b_wr_data = db[SIZE-1-i];
         tick();
      end
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!done && cnt < 200) begin
         tick();
         cnt++;
      end
   endtask

   task automatic check_result(input string tag, input logic p, input logic t,
                               input int mc, input int fa);
      check({tag, ".done"},  32'(done), 32'd1);
      check({tag, ".pass"},  32'(pass), 32'(p));
      check({tag, ".tmo"},   32'(timeout), 32'(t));
      check({tag, ".mcnt"},  32'(mismatch_count), 32'(mc));
      check({tag, ".first"}, 32'(first_mismatch_addr), 32'(fa));
   endtask

   task automatic set_match();
      for (int i = 0; i < SIZE; i++) begin
         da[i] = 32'((i + 1) * 10);
         db[i] = 32'((i + 1) * 10);
      end
   endtask

   initial begin
      tick();
      tick();
      check("rst.done",  32'(done), 32'd0);
      check("rst.pass",  32'(pass), 32'd0);
      check("rst.tmo",   32'(timeout), 32'd0);
      check("rst.mcnt",  32'(mismatch_count), 32'd0);
      check("rst.first", 32'(first_mismatch_addr), 32'd0);
      rst = 1'b0;
      tick();

      // identical data, opposite write order
      set_match();
      pulse_start();
      do_writes('0, '0);
      wait_done(lat);
      check("ident.lat", 32'(lat), 32'd9);
      check_result("ident", 1'b1, 1'b0, 0, 0);

      // two mismatches at 2 and 5
      db[2] = 32'd99;
      db[5] = 32'd77;
      pulse_start();
      do_writes('0, '0);
      wait_done(lat);
      check("mis.lat", 32'(lat), 32'd9);
      check_result("mis", 1'b0, 1'b0, 2, 2);

      // rewrite on A addr 3, simultaneous writes to addr 0
      set_match();
      pulse_start();
      a_wr_en = 1'b1; a_addr = 3'd3; a_wr_data = 32'd5;
      tick();
      for (int i = 0; i < SIZE; i++) begin
         a_wr_en = 1'b1; a_addr = ADDR_W'(i); a_wr_data = da[i];
         b_wr_en = 1'b1; b_addr = ADDR_W'(i); b_wr_data = db[i];
         tick();
      end
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
      wait_done(lat);
      check("rew.lat", 32'(lat), 32'd9);
      check_result("rew", 1'b1, 1'b0, 0, 0);

      // B never writes addr 7
      pulse_start();
      do_writes('0, 8'h80);
      wait_done(lat);
      check("tmo.lat", 32'(lat + SIZE), 32'(TMO));
      check_result("tmo", 1'b0, 1'b1, 0, 0);

      // reset in the middle of COMPARE, after a mismatch was already seen
      db[2] = 32'd99;
      pulse_start();
      do_writes('0, '0);
      for (int i = 0; i < 5; i++) tick();
      check("midrst.pre", 32'(done), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst.done",  32'(done), 32'd0);
      check("midrst.pass",  32'(pass), 32'd0);
      check("midrst.tmo",   32'(timeout), 32'd0);
      check("midrst.mcnt",  32'(mismatch_count), 32'd0);
      check("midrst.first", 32'(first_mismatch_addr), 32'd0);
      for (int i = 0; i < 12; i++) tick();
      check("midrst.idle", 32'(done), 32'd0);

      set_match();
      pulse_start();
      do_writes('0, '0);
      wait_done(lat);
      check("rerun.lat", 32'(lat), 32'd9);
      check_result("rerun", 1'b1, 1'b0, 0, 0);

      // A write on the start cycle is dropped; addr 4 never rewritten
      a_wr_en = 1'b1; a_addr = 3'd4; a_wr_data = da[4];
      pulse_start();
      a_wr_en = 1'b0;
      do_writes(8'h10, '0);
      wait_done(lat);
      check("stcyc.lat", 32'(lat + SIZE), 32'(TMO));
      check_result("stcyc", 1'b0, 1'b1, 0, 0);

      // failing run, then restart from DONE with matching data
      db[6] = 32'd1;
      pulse_start();
      do_writes('0, '0);
      wait_done(lat);
      check_result("fail6", 1'b0, 1'b0, 1, 6);
      set_match();
      pulse_start();
      check("restart.clr", 32'(mismatch_count), 32'd0);
      do_writes('0, '0);
      wait_done(lat);
      check_result("restart", 1'b1, 1'b0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
